issue_exec_stage_mult_pipe: RTL and testbench

// Parametrised, fully pipelined multiply execute stage between a reservation station (RS) and
// the execute-decision/CDB arbiter. Accepts one op per cycle, supports RISC-V MUL/MULH/MULHSU/MULHU.

---
 rtl/issue_exec_stage_mult_pipe.sv | 188 ++++++++++++++++++
 tb/tb_issue_exec_stage_mult_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_exec_stage_mult_pipe.sv
`default_nettype none
// ============================================================================
// issue_exec_stage_mult_pipe : pipelined RV MUL/MULH/MULHSU/MULHU stage with an in-order output FIFO
// Optional feature macro: ISSUE_MULT_FLUSH_EN (adds flush_i).        Revision: 1.0
// ============================================================================
module issue_exec_stage_mult_pipe #(
  parameter int WIDTH      = 64,
  parameter int LATENCY    = 3,
  parameter int OUT_DEPTH  = 4,
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
`ifdef ISSUE_MULT_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  readyRS_i,
  output logic                  stallRS_o,
  input  logic [WIDTH-1:0]      reservationStationVal1_i,
  input  logic [WIDTH-1:0]      reservationStationVal2_i,
  input  logic [9:0]            reservationStationCommands_i,
  input  logic [ROBsizeLog-1:0] reservationStationTag_i,
  input  logic [1:0]            mulOp_i,
  input  logic                  canGo_i,
  output logic                  valid_o,
  output logic [WIDTH-1:0]      executeVal_o,
  output logic [9:0]            executeCommands_o,
  output logic [ROBsizeLog-1:0] executeTag_o,
  output logic [3:0]            executeFlags_o
);

  localparam int c_cnt_w = $clog2(OUT_DEPTH + 1);
  localparam int c_ptr_w = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(OUT_DEPTH - 1);
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(OUT_DEPTH);

  localparam logic [1:0] c_op_mul    = 2'b00;
  localparam logic [1:0] c_op_mulh   = 2'b01;
  localparam logic [1:0] c_op_mulhsu = 2'b10;

  logic                  w_accept;
  logic                  w_pop;
  logic [c_cnt_w-1:0]    r_cnt;

  // Pipeline state: operands live only in stage 0, the result is carried afterwards.
  logic [LATENCY-1:0]    r_vld;
  logic [WIDTH-1:0]      r_a0;
  logic [WIDTH-1:0]      r_b0;
  logic [1:0]            r_op0;
  logic [9:0]            r_cmd [LATENCY];
  logic [ROBsizeLog-1:0] r_tag [LATENCY];

  logic                  w_a_sext;
  logic                  w_b_sext;
  logic [2*WIDTH-1:0]    w_a_ext;
  logic [2*WIDTH-1:0]    w_b_ext;
  logic [2*WIDTH-1:0]    w_prod;
  logic [WIDTH-1:0]      w_res;

  logic                  w_fin_vld;
  logic [WIDTH-1:0]      w_fin_res;
  logic [3:0]            w_fin_flags;

  logic [WIDTH-1:0]      r_mem_val [OUT_DEPTH];
  logic [9:0]            r_mem_cmd [OUT_DEPTH];
  logic [ROBsizeLog-1:0] r_mem_tag [OUT_DEPTH];
  logic [3:0]            r_mem_flg [OUT_DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_fcnt;

  function automatic logic [c_ptr_w-1:0] f_next_ptr(input logic [c_ptr_w-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  assign w_accept  = readyRS_i & ~stallRS_o;
  assign w_pop     = valid_o & canGo_i;
  // Credits come straight from a register, so canGo_i never reaches stallRS_o combinationally.
  assign stallRS_o = (r_cnt == c_full_cnt);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= '0;
`ifdef ISSUE_MULT_FLUSH_EN
    end else if (flush_i) begin
      r_cnt <= '0;
`endif
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(w_accept) - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_vld <= '0;
`ifdef ISSUE_MULT_FLUSH_EN
    end else if (flush_i) begin
      r_vld <= '0;
`endif
    end else begin
      r_vld[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_a0     <= reservationStationVal1_i;
      r_b0     <= reservationStationVal2_i;
      r_op0    <= mulOp_i;
      r_cmd[0] <= reservationStationCommands_i;
      r_tag[0] <= reservationStationTag_i;
    end
    for (int i = 1; i < LATENCY; i++) begin
      r_cmd[i] <= r_cmd[i-1];
      r_tag[i] <= r_tag[i-1];
    end
  end

  // Sign-extending both operands to 2*WIDTH makes one unsigned multiplier cover all four ops.
  always_comb begin
    w_a_sext = (r_op0 == c_op_mulh) || (r_op0 == c_op_mulhsu);
    w_b_sext = (r_op0 == c_op_mulh);
    w_a_ext  = {{WIDTH{w_a_sext & r_a0[WIDTH-1]}}, r_a0};
    w_b_ext  = {{WIDTH{w_b_sext & r_b0[WIDTH-1]}}, r_b0};
    w_prod   = w_a_ext * w_b_ext;
    w_res    = (r_op0 == c_op_mul) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
  end

  if (LATENCY == 1) begin : g_res_direct
    assign w_fin_res = w_res;
  end else begin : g_res_pipe
    logic [WIDTH-1:0] r_res [1:LATENCY-1];
    always_ff @(posedge clk_i) begin
      r_res[1] <= w_res;
      for (int i = 2; i < LATENCY; i++) begin
        r_res[i] <= r_res[i-1];
      end
    end
    assign w_fin_res = r_res[LATENCY-1];
  end

  assign w_fin_vld   = r_vld[LATENCY-1];
  assign w_fin_flags = {2'b00, w_fin_res[WIDTH-1], (w_fin_res == '0)};

  always_ff @(posedge clk_i) begin
    if (w_fin_vld) begin
      r_mem_val[r_wr_ptr] <= w_fin_res;
      r_mem_cmd[r_wr_ptr] <= r_cmd[LATENCY-1];
      r_mem_tag[r_wr_ptr] <= r_tag[LATENCY-1];
      r_mem_flg[r_wr_ptr] <= w_fin_flags;
    end
  end

  // The credit counter bounds in-flight ops to OUT_DEPTH, so the FIFO cannot overflow.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
`ifdef ISSUE_MULT_FLUSH_EN
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
`endif
    end else begin
      if (w_fin_vld) begin
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
      r_fcnt <= r_fcnt + c_cnt_w'(w_fin_vld) - c_cnt_w'(w_pop);
    end
  end

  assign valid_o           = (r_fcnt != '0);
  assign executeVal_o      = valid_o ? r_mem_val[r_rd_ptr] : '0;
  assign executeCommands_o = valid_o ? r_mem_cmd[r_rd_ptr] : '0;
  assign executeTag_o      = valid_o ? r_mem_tag[r_rd_ptr] : '0;
  assign executeFlags_o    = valid_o ? r_mem_flg[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_issue_exec_stage_mult_pipe.sv
`default_nettype none
// ============================================================================
// tb_issue_exec_stage_mult_pipe : vector table + scoreboard bench for the multiply stage
// Revision: 1.0
// ============================================================================
module tb_issue_exec_stage_mult_pipe;

  localparam int W   = 64;
  localparam int TW  = 6;
  localparam int DEP = 4;

  logic          clk;
  logic          reset_n;
  logic          readyRS;
  logic          stallRS;
  logic [W-1:0]  val1;
  logic [W-1:0]  val2;
  logic [9:0]    cmds;
  logic [TW-1:0] tag;
  logic [1:0]    mulop;
  logic          canGo;
  logic          valid;
  logic [W-1:0]  eval;
  logic [9:0]    ecmd;
  logic [TW-1:0] etag;
  logic [3:0]    eflg;
`ifdef ISSUE_MULT_FLUSH_EN
  logic          flush;
`endif

  issue_exec_stage_mult_pipe #(
    .WIDTH(W), .LATENCY(3), .OUT_DEPTH(DEP), .ROBsize(32)
  ) dut (
    .clk_i                        (clk),
    .reset_n_i                    (reset_n),
`ifdef ISSUE_MULT_FLUSH_EN
    .flush_i                      (flush),
`endif
    .readyRS_i                    (readyRS),
    .stallRS_o                    (stallRS),
    .reservationStationVal1_i     (val1),
    .reservationStationVal2_i     (val2),
    .reservationStationCommands_i (cmds),
    .reservationStationTag_i      (tag),
    .mulOp_i                      (mulop),
    .canGo_i                      (canGo),
    .valid_o                      (valid),
    .executeVal_o                 (eval),
    .executeCommands_o            (ecmd),
    .executeTag_o                 (etag),
    .executeFlags_o               (eflg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  val;
    logic [9:0]    cmd;
    logic [TW-1:0] tag;
    logic [3:0]    flg;
  } res_t;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    op;
    logic [9:0]    cmd;
    logic [TW-1:0] tag;
    logic [W-1:0]  exp;
    logic [3:0]    flg;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;
  res_t m_q[$];
  res_t m_pipe[3];
  logic [2:0] m_pv = '0;
  int   m_cnt = 0;
  res_t cur;
  bit   last_acc;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    logic signed [2*W-1:0] p;
    sa = (op == 2'b11) ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
    sb = (op == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  function automatic logic [3:0] ref_flg(input logic [W-1:0] v);
    return {2'b00, v[W-1], (v == '0)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pv  = '0;
    m_cnt = 0;
  endtask

  // Check the state visible before the coming edge, then advance the model across it.
  task automatic cycle();
    bit   acc;
    bit   pop;
    bit   fl;
    res_t h;
    acc = readyRS && !stallRS;
    pop = valid && canGo;
    fl  = 1'b0;
`ifdef ISSUE_MULT_FLUSH_EN
    fl  = flush;
`endif
    chk("stall", stallRS, m_cnt == DEP);
    chk("valid", valid, m_q.size() != 0);
    if (valid && m_q.size() != 0) begin
      h = m_q[0];
      chk("val", eval, h.val);
      chk("cmd", ecmd, h.cmd);
      chk("tag", etag, h.tag);
      chk("flags", eflg, h.flg);
    end else if (!valid) begin
      chk("idle_val", eval, '0);
      chk("idle_meta", {ecmd, etag, eflg}, '0);
    end
    last_acc = acc && !fl;
    if (fl) begin
      model_reset();
    end else begin
      if (pop && m_q.size() != 0) begin
        void'(m_q.pop_front());
        n_out++;
      end
      if (m_pv[2]) m_q.push_back(m_pipe[2]);
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = cur;
      m_pv  = {m_pv[1:0], acc};
      m_cnt = m_cnt + int'(acc) - int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic present(input vec_t v);
    val1    = v.a;
    val2    = v.b;
    mulop   = v.op;
    cmds    = v.cmd;
    tag     = v.tag;
    readyRS = 1'b1;
    cur.val = v.exp;
    cur.cmd = v.cmd;
    cur.tag = v.tag;
    cur.flg = v.flg;
  endtask

  task automatic issue(input vec_t v);
    int n;
    n = 0;
    present(v);
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 20);
    chk("accept_timeout", last_acc, 1'b1);
  endtask

  function automatic vec_t rand_vec(input logic [TW-1:0] t);
    vec_t v;
    v.a   = {$urandom, $urandom};
    v.b   = {$urandom, $urandom};
    v.op  = 2'($urandom_range(0, 3));
    v.cmd = 10'($urandom_range(0, 1023));
    v.tag = t;
    v.exp = ref_mul(v.a, v.b, v.op);
    v.flg = ref_flg(v.exp);
    return v;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    readyRS = 1'b0;
    canGo   = 1'b1;
    while ((m_q.size() != 0 || m_pv != '0 || m_cnt != 0) && n < 60) begin
      cycle();
      n++;
    end
    chk("drain_timeout", (m_q.size() != 0 || m_pv != '0), 1'b0);
  endtask

  vec_t tbl[10];
  vec_t v;
  int   lat;
  int   n0;
  bit   saw_stall;

  initial begin
    // a, b, op, cmd, tag, expected result, expected flags
    tbl[0] = '{64'd3, 64'd5, 2'b00, 10'h02A, 6'd7, 64'd15, 4'b0000};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b11, 10'h001, 6'd1, 64'd1, 4'b0000};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b01, 10'h002, 6'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 4'b0010};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b10, 10'h003, 6'd3,
               64'hFFFF_FFFF_FFFF_FFFF, 4'b0010};
    tbl[4] = '{64'd0, 64'd9, 2'b00, 10'h004, 6'd4, 64'd0, 4'b0001};
    tbl[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 10'h005, 6'd5,
               64'h4000_0000_0000_0000, 4'b0000};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 10'h006, 6'd6,
               64'hFFFF_FFFF_FFFF_FFFE, 4'b0010};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 10'h007, 6'd8,
               64'd1, 4'b0000};
    tbl[8] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 10'h008, 6'd9,
               64'h8000_0000_0000_0000, 4'b0010};
    tbl[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b00, 10'h3FF, 6'd32,
               64'hFFFF_FFFF_FFFF_FFFE, 4'b0010};

    reset_n = 1'b0;
    readyRS = 1'b0;
    canGo   = 1'b0;
    val1 = '0; val2 = '0; cmds = '0; tag = '0; mulop = '0;
    cur  = '0;
`ifdef ISSUE_MULT_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_stall", stallRS, 1'b0);
    chk("rst_val", eval, '0);
    chk("rst_meta", {ecmd, etag, eflg}, '0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();

    // Single MUL: valid_o three edges after acceptance, then gone.
    canGo = 1'b1;
    issue(tbl[0]);
    readyRS = 1'b0;
    lat = 0;
    while (!valid && lat < 10) begin
      cycle();
      lat++;
    end
    chk("latency", lat, 3);
    repeat (2) cycle();

    // Arithmetic corners back-to-back.
    for (int i = 0; i < 10; i++) issue(tbl[i]);
    drain();

    // Backpressure: four held, fifth waits on stall, all six come out in order.
    canGo = 1'b0;
    n0 = n_out;
    for (int t = 0; t < 4; t++) issue(rand_vec(6'(t)));
    v = rand_vec(6'd4);
    present(v);
    saw_stall = 1'b0;
    repeat (3) begin
      if (stallRS) saw_stall = 1'b1;
      cycle();
      chk("held_while_stalled", last_acc, 1'b0);
    end
    chk("saw_stall", saw_stall, 1'b1);
    canGo = 1'b1;
    issue(v);
    issue(rand_vec(6'd5));
    drain();
    chk("bp_count", n_out - n0, 6);

    // Streaming with the sink always ready.
    n0 = n_out;
    canGo = 1'b1;
    for (int i = 0; i < 20; i++) issue(rand_vec(6'(10 + i)));
    drain();
    chk("stream_count", n_out - n0, 20);

    // Asynchronous reset with one result at the head and one op still in the pipeline.
    canGo = 1'b0;
    issue(rand_vec(6'd40));
    issue(rand_vec(6'd41));
    readyRS = 1'b0;
    repeat (2) cycle();
    chk("pre_rst_valid", valid, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", valid, 1'b0);
    chk("async_rst_stall", stallRS, 1'b0);
    chk("async_rst_val", eval, '0);
    chk("async_rst_meta", {ecmd, etag, eflg}, '0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    canGo = 1'b1;
    repeat (5) cycle();

`ifdef ISSUE_MULT_FLUSH_EN
    // Flush with three ops in the pipeline and one in the FIFO.
    canGo = 1'b0;
    for (int t = 0; t < 4; t++) issue(rand_vec(6'(50 + t)));
    readyRS = 1'b0;
    flush   = 1'b1;
    cycle();
    flush   = 1'b0;
    chk("flush_valid", valid, 1'b0);
    chk("flush_stall", stallRS, 1'b0);
    canGo = 1'b1;
    n0 = n_out;
    issue(rand_vec(6'd60));
    readyRS = 1'b0;
    lat = 0;
    while (!valid && lat < 10) begin
      cycle();
      lat++;
    end
    chk("flush_latency", lat, 3);
    drain();
    chk("flush_count", n_out - n0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
